// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, funct3 groups, ALU ops, datapath mux selects and the control word.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [1:0] {
    pcmux_pc_plus4 = 2'b00,
    pcmux_alu_out  = 2'b01,
    pcmux_alu_mod2 = 2'b10
  } pcmux_sel_t;

  typedef enum logic {
    alumux1_rs1 = 1'b0,
    alumux1_pc  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm = 3'b000,
    alumux2_u_imm = 3'b001,
    alumux2_b_imm = 3'b010,
    alumux2_s_imm = 3'b011,
    alumux2_j_imm = 3'b100,
    alumux2_rs2   = 3'b101
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    rfmux_alu_out  = 4'd0,
    rfmux_br_en    = 4'd1,
    rfmux_u_imm    = 4'd2,
    rfmux_lw       = 4'd3,
    rfmux_pc_plus4 = 4'd4,
    rfmux_lb       = 4'd5,
    rfmux_lbu      = 4'd6,
    rfmux_lh       = 4'd7,
    rfmux_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {
    cmpmux_rs2   = 1'b0,
    cmpmux_i_imm = 1'b1
  } cmpmux_sel_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    cmpmux_sel_t     cmpmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      mem_byte_enable;
  } rv32i_control_word;

endpackage

// File: rtl/branch_cmp.sv
// Branch comparator: signed/unsigned relational test selected by the branch funct3.
module branch_cmp
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  branch_funct3_t   cmpop_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             br_en_o
);

  // Relational result for the selected compare
  always_comb begin
    br_en_o = 1'b0;
    case (cmpop_i)
      beq:     br_en_o = (a_i == b_i);
      bne:     br_en_o = (a_i != b_i);
      blt:     br_en_o = ($signed(a_i) <  $signed(b_i));
      bge:     br_en_o = ($signed(a_i) >= $signed(b_i));
      bltu:    br_en_o = (a_i <  b_i);
      bgeu:    br_en_o = (a_i >= b_i);
      default: br_en_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_decode_unit.sv
// ID-stage decode, branch compare, next-PC resolution and mispredict flush.
// Optional self-loop halt detection is built only when SELF_LOOP_HALT_EN is defined.
module branch_decode_unit
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  instr_i,
  input  logic [WIDTH-1:0]  pc_i,
  input  logic [WIDTH-1:0]  rs1_val_i,
  input  logic [WIDTH-1:0]  rs2_val_i,
  input  logic              br_pred_i,
  input  logic              nop_i,
  output rv32i_control_word ctrl_o,
  output logic              br_en_o,
  output logic [WIDTH-1:0]  target_o,
  output pcmux_sel_t        pcmux_sel_o,
  output logic              flush_o,
  output logic              halt_en_o,
  output logic              halted_o
);

  rv32i_opcode       opcode_s;
  logic [2:0]        funct3_s;
  logic [WIDTH-1:0]  i_imm_s, s_imm_s, b_imm_s, u_imm_s, j_imm_s;
  logic [WIDTH-1:0]  cmp_b_s;
  logic [WIDTH-1:0]  jalr_sum_s;
  rv32i_control_word rom_s;
  rv32i_control_word ctrl_s;
  logic              br_en_s;
  logic [WIDTH-1:0]  target_s;
  pcmux_sel_t        pcmux_sel_s;

  assign opcode_s = rv32i_opcode'(instr_i[6:0]);
  assign funct3_s = instr_i[14:12];
  assign i_imm_s  = {{21{instr_i[31]}}, instr_i[30:20]};
  assign s_imm_s  = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
  assign b_imm_s  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm_s  = {instr_i[31:12], 12'h000};
  assign j_imm_s  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Control ROM indexed by the raw opcode
  always_comb begin
    rom_s       = '0;
    rom_s.cmpop = beq;
    case (opcode_s)
      op_lui: begin
        rom_s.opcode         = op_lui;
        rom_s.load_regfile   = 1'b1;
        rom_s.regfilemux_sel = rfmux_u_imm;
      end
      op_auipc: begin
        rom_s.opcode      = op_auipc;
        rom_s.aluop       = alu_add;
        rom_s.alumux1_sel = alumux1_pc;
        rom_s.alumux2_sel = alumux2_u_imm;
      end
      op_jal, op_jalr: begin
        rom_s.opcode         = opcode_s;
        rom_s.load_regfile   = 1'b1;
        rom_s.regfilemux_sel = rfmux_pc_plus4;
      end
      op_br: begin
        rom_s.opcode     = op_br;
        rom_s.cmpop      = branch_funct3_t'(funct3_s);
        rom_s.cmpmux_sel = cmpmux_rs2;
      end
      op_load: begin
        rom_s.opcode      = op_load;
        rom_s.aluop       = alu_add;
        rom_s.alumux1_sel = alumux1_rs1;
        rom_s.alumux2_sel = alumux2_i_imm;
        rom_s.mem_read    = 1'b1;
        case (load_funct3_t'(funct3_s))
          lb:      rom_s.regfilemux_sel = rfmux_lb;
          lh:      rom_s.regfilemux_sel = rfmux_lh;
          lw:      rom_s.regfilemux_sel = rfmux_lw;
          lbu:     rom_s.regfilemux_sel = rfmux_lbu;
          lhu:     rom_s.regfilemux_sel = rfmux_lhu;
          default: rom_s.regfilemux_sel = rfmux_lw;
        endcase
      end
      op_store: begin
        rom_s.opcode      = op_store;
        rom_s.aluop       = alu_add;
        rom_s.alumux1_sel = alumux1_rs1;
        rom_s.alumux2_sel = alumux2_s_imm;
        rom_s.mem_write   = 1'b1;
        case (store_funct3_t'(funct3_s))
          sb:      rom_s.mem_byte_enable = 4'b0001;
          sh:      rom_s.mem_byte_enable = 4'b0011;
          sw:      rom_s.mem_byte_enable = 4'b1111;
          default: rom_s.mem_byte_enable = 4'b0000;
        endcase
      end
      op_imm, op_reg: begin
        rom_s.opcode         = opcode_s;
        rom_s.alumux1_sel    = alumux1_rs1;
        rom_s.alumux2_sel    = (opcode_s == op_imm) ? alumux2_i_imm : alumux2_rs2;
        rom_s.cmpmux_sel     = (opcode_s == op_imm) ? cmpmux_i_imm : cmpmux_rs2;
        rom_s.regfilemux_sel = rfmux_alu_out;
        case (arith_funct3_t'(funct3_s))
          f3_slt: begin
            rom_s.cmpop          = blt;
            rom_s.regfilemux_sel = rfmux_br_en;
          end
          f3_sltu: begin
            rom_s.cmpop          = bltu;
            rom_s.regfilemux_sel = rfmux_br_en;
          end
          // Immediate adds never subtract; instr[30] is part of the immediate there
          f3_add: begin
            if ((opcode_s == op_reg) && instr_i[30]) begin
              rom_s.aluop = alu_sub;
            end else begin
              rom_s.aluop = alu_add;
            end
          end
          f3_sr: begin
            if (instr_i[30]) begin
              rom_s.aluop = alu_sra;
            end else begin
              rom_s.aluop = alu_srl;
            end
          end
          default: rom_s.aluop = alu_ops'(funct3_s);
        endcase
      end
      default: rom_s = '0;
    endcase
  end

  // Hazard bubble: turn the word into a side-effect-free op_csr slot
  always_comb begin
    ctrl_s = rom_s;
    if (nop_i) begin
      ctrl_s.opcode          = op_csr;
      ctrl_s.load_regfile    = 1'b0;
      ctrl_s.mem_read        = 1'b0;
      ctrl_s.mem_write       = 1'b0;
      ctrl_s.mem_byte_enable = 4'b0000;
      ctrl_s.alumux1_sel     = alumux1_rs1;
      ctrl_s.alumux2_sel     = alumux2_rs2;
      ctrl_s.regfilemux_sel  = rfmux_alu_out;
    end else begin
      ctrl_s = rom_s;
    end
  end

  assign cmp_b_s = (rom_s.cmpmux_sel == cmpmux_i_imm) ? i_imm_s : rs2_val_i;

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .cmpop_i (rom_s.cmpop),
    .a_i     (rs1_val_i),
    .b_i     (cmp_b_s),
    .br_en_o (br_en_s)
  );

  assign jalr_sum_s = rs1_val_i + i_imm_s;

  // Next-PC resolver driven by the undecorated opcode
  always_comb begin
    target_s    = pc_i + 32'd4;
    pcmux_sel_s = pcmux_pc_plus4;
    case (opcode_s)
      op_br: begin
        if (br_en_s) begin
          target_s    = pc_i + b_imm_s;
          pcmux_sel_s = pcmux_alu_out;
        end else begin
          target_s    = pc_i + 32'd4;
          pcmux_sel_s = pcmux_pc_plus4;
        end
      end
      op_jal: begin
        target_s    = pc_i + j_imm_s;
        pcmux_sel_s = pcmux_alu_out;
      end
      op_jalr: begin
        target_s    = {jalr_sum_s[WIDTH-1:1], 1'b0};
        pcmux_sel_s = pcmux_alu_mod2;
      end
      default: begin
        target_s    = pc_i + 32'd4;
        pcmux_sel_s = pcmux_pc_plus4;
      end
    endcase
  end

  assign ctrl_o      = ctrl_s;
  assign br_en_o     = br_en_s;
  assign target_o    = target_s;
  assign pcmux_sel_o = pcmux_sel_s;
  assign flush_o     = ((ctrl_s.opcode == op_br) && (br_en_s != br_pred_i)) ||
                       (((ctrl_s.opcode == op_jal) || (ctrl_s.opcode == op_jalr)) && !br_pred_i);

`ifdef SELF_LOOP_HALT_EN
  logic halt_en_s;
  logic halted_d, halted_q;

  assign halt_en_s = br_en_s && (target_s == pc_i) && (ctrl_s.opcode != 7'h00) && rst;
  assign halted_d  = halted_q | halt_en_s;

  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halt_en_o = halt_en_s;
  assign halted_o  = halted_q;
`else
  logic unused_s;

  assign unused_s  = ^{clk, rst};
  assign halt_en_o = 1'b0;
  assign halted_o  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_decode_unit.sv
// Directed + randomized scoreboard bench for branch_decode_unit; halt expectations follow SELF_LOOP_HALT_EN.
module tb_branch_decode_unit;
  import rv32i_types::*;

`ifdef SELF_LOOP_HALT_EN
  localparam logic [31:0] HALT_ON = 32'd1;
`else
  localparam logic [31:0] HALT_ON = 32'd0;
`endif

  localparam int S_BR_EN = 0, S_TARGET = 1, S_PCMUX = 2, S_FLUSH = 3, S_HALT_EN = 4,
                 S_HALTED = 5, S_MEM_WRITE = 6, S_OPCODE = 7, S_BYTE_EN = 8, S_ALUOP = 9,
                 S_ALUMUX2 = 10, S_CMPOP = 11, S_CMPMUX = 12, S_RFMUX = 13, S_LOAD_RF = 14,
                 S_MEM_READ = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       instr, pc, rs1_val, rs2_val;
  logic              br_pred, nop;
  rv32i_control_word ctrl;
  logic              br_en, flush, halt_en, halted;
  logic [31:0]       target;
  pcmux_sel_t        pcmux_sel;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  logic [2:0] f3_tab [0:5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  always #5 clk = ~clk;

  branch_decode_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_i     (instr),
    .pc_i        (pc),
    .rs1_val_i   (rs1_val),
    .rs2_val_i   (rs2_val),
    .br_pred_i   (br_pred),
    .nop_i       (nop),
    .ctrl_o      (ctrl),
    .br_en_o     (br_en),
    .target_o    (target),
    .pcmux_sel_o (pcmux_sel),
    .flush_o     (flush),
    .halt_en_o   (halt_en),
    .halted_o    (halted)
  );

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [6:0] op);
    return {imm, rs1, f3, 5'd1, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {f7, rs2, rs1, f3, 5'd1, 7'h33};
  endfunction

  function automatic logic model_br(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_BR_EN:     return {31'd0, br_en};
      S_TARGET:    return target;
      S_PCMUX:     return 32'(pcmux_sel);
      S_FLUSH:     return {31'd0, flush};
      S_HALT_EN:   return {31'd0, halt_en};
      S_HALTED:    return {31'd0, halted};
      S_MEM_WRITE: return {31'd0, ctrl.mem_write};
      S_OPCODE:    return 32'(ctrl.opcode);
      S_BYTE_EN:   return 32'(ctrl.mem_byte_enable);
      S_ALUOP:     return 32'(ctrl.aluop);
      S_ALUMUX2:   return 32'(ctrl.alumux2_sel);
      S_CMPOP:     return 32'(ctrl.cmpop);
      S_CMPMUX:    return 32'(ctrl.cmpmux_sel);
      S_RFMUX:     return 32'(ctrl.regfilemux_sel);
      S_LOAD_RF:   return {31'd0, ctrl.load_regfile};
      S_MEM_READ:  return {31'd0, ctrl.mem_read};
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string tag_of(int sel);
    case (sel)
      S_BR_EN:     return "br_en";
      S_TARGET:    return "target";
      S_PCMUX:     return "pcmux_sel";
      S_FLUSH:     return "flush";
      S_HALT_EN:   return "halt_en";
      S_HALTED:    return "halted";
      S_MEM_WRITE: return "mem_write";
      S_OPCODE:    return "opcode";
      S_BYTE_EN:   return "byte_en";
      S_ALUOP:     return "aluop";
      S_ALUMUX2:   return "alumux2";
      S_CMPOP:     return "cmpop";
      S_CMPMUX:    return "cmpmux";
      S_RFMUX:     return "regfilemux";
      S_LOAD_RF:   return "load_regfile";
      S_MEM_READ:  return "mem_read";
      default:     return "unknown";
    endcase
  endfunction

  task automatic drive(logic [31:0] i, logic [31:0] p, logic [31:0] a, logic [31:0] b, logic pr, logic n);
    @(negedge clk);
    instr   = i;
    pc      = p;
    rs1_val = a;
    rs2_val = b;
    br_pred = pr;
    nop     = n;
  endtask

  task automatic expect_val(int sel, logic [31:0] v);
    exp_t e;
    e.sel = sel;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic settle_and_check();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag_of(e.sel), obs, e.val);
      end
    end
  endtask

  initial begin
    logic [31:0] rpc, ra, rb, rexp_t;
    logic [12:0] rimm;
    logic [2:0]  rf3;
    logic        rpred, rbr;

    rst = 1'b0;
    instr = 32'h0000_0013; pc = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
    br_pred = 1'b0; nop = 1'b0;

    // Self-loop held in reset must not raise halt
    drive(enc_b(13'd0, 5'd0, 5'd0, 3'd0), 32'h80, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_val(S_BR_EN, 32'd1); expect_val(S_HALT_EN, 32'd0); expect_val(S_HALTED, 32'd0);
    settle_and_check();
    drive(32'h0000_0013, 32'h84, 32'd0, 32'd1, 1'b0, 1'b0);
    rst = 1'b1;
    expect_val(S_HALTED, 32'd0);
    settle_and_check();

    // beq x1,x2,+8 taken, predicted not-taken
    drive(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h100, 32'd5, 32'd5, 1'b0, 1'b0);
    expect_val(S_BR_EN, 32'd1); expect_val(S_TARGET, 32'h108);
    expect_val(S_PCMUX, 32'(pcmux_alu_out)); expect_val(S_FLUSH, 32'd1); expect_val(S_HALT_EN, 32'd0);
    settle_and_check();

    // Same branch as a bubble: no flush, comparator still raw
    drive(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h100, 32'd5, 32'd5, 1'b0, 1'b1);
    expect_val(S_BR_EN, 32'd1); expect_val(S_FLUSH, 32'd0); expect_val(S_OPCODE, 32'h73);
    settle_and_check();

    // bltu vs blt on 0xFFFFFFFF / 1
    drive(enc_b(13'd16, 5'd2, 5'd1, 3'd6), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    expect_val(S_BR_EN, 32'd0); expect_val(S_TARGET, 32'h204);
    expect_val(S_PCMUX, 32'(pcmux_pc_plus4)); expect_val(S_FLUSH, 32'd0);
    settle_and_check();
    drive(enc_b(13'd16, 5'd2, 5'd1, 3'd4), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    expect_val(S_BR_EN, 32'd1); expect_val(S_TARGET, 32'h210); expect_val(S_FLUSH, 32'd1);
    expect_val(S_CMPOP, 32'(blt));
    settle_and_check();
    drive(enc_b(13'd16, 5'd2, 5'd1, 3'd4), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    expect_val(S_FLUSH, 32'd0);
    settle_and_check();

    // jalr clears bit 0 of rs1+imm
    drive(enc_i(12'd4, 5'd1, 3'd0, 7'h67), 32'h400, 32'h1003, 32'd0, 1'b0, 1'b0);
    expect_val(S_TARGET, 32'h1006); expect_val(S_PCMUX, 32'(pcmux_alu_mod2)); expect_val(S_FLUSH, 32'd1);
    expect_val(S_LOAD_RF, 32'd1); expect_val(S_RFMUX, 32'(rfmux_pc_plus4));
    settle_and_check();
    drive(enc_i(12'd4, 5'd1, 3'd0, 7'h67), 32'h400, 32'h1003, 32'd0, 1'b1, 1'b0);
    expect_val(S_FLUSH, 32'd0);
    settle_and_check();

    // jal backward by 4
    drive(enc_j(21'h1F_FFFC), 32'h300, 32'd0, 32'd7, 1'b0, 1'b0);
    expect_val(S_TARGET, 32'h2FC); expect_val(S_PCMUX, 32'(pcmux_alu_out)); expect_val(S_FLUSH, 32'd1);
    settle_and_check();

    // Stores, bubbled and live
    drive(enc_s(12'd0, 5'd2, 5'd1, 3'd2), 32'h500, 32'd1, 32'd2, 1'b0, 1'b1);
    expect_val(S_MEM_WRITE, 32'd0); expect_val(S_OPCODE, 32'h73); expect_val(S_FLUSH, 32'd0);
    expect_val(S_BYTE_EN, 32'd0); expect_val(S_ALUMUX2, 32'(alumux2_rs2));
    settle_and_check();
    drive(enc_s(12'd0, 5'd2, 5'd1, 3'd2), 32'h500, 32'd1, 32'd2, 1'b0, 1'b0);
    expect_val(S_MEM_WRITE, 32'd1); expect_val(S_BYTE_EN, 32'hF); expect_val(S_OPCODE, 32'h23);
    expect_val(S_ALUMUX2, 32'(alumux2_s_imm));
    settle_and_check();
    drive(enc_s(12'd0, 5'd2, 5'd1, 3'd0), 32'h500, 32'd1, 32'd2, 1'b0, 1'b0);
    expect_val(S_BYTE_EN, 32'h1);
    settle_and_check();
    drive(enc_s(12'd0, 5'd2, 5'd1, 3'd1), 32'h500, 32'd1, 32'd2, 1'b0, 1'b0);
    expect_val(S_BYTE_EN, 32'h3);
    settle_and_check();

    // ALU immediate / register decode
    drive(enc_i({7'h20, 5'd3}, 5'd1, 3'd5, 7'h13), 32'h600, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_val(S_ALUOP, 32'(alu_sra)); expect_val(S_ALUMUX2, 32'(alumux2_i_imm));
    settle_and_check();
    drive(enc_i(12'd3, 5'd1, 3'd2, 7'h13), 32'h600, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
    expect_val(S_CMPOP, 32'(blt)); expect_val(S_CMPMUX, 32'(cmpmux_i_imm));
    expect_val(S_RFMUX, 32'(rfmux_br_en)); expect_val(S_BR_EN, 32'd1);
    settle_and_check();
    drive(enc_i(12'd3, 5'd1, 3'd3, 7'h13), 32'h600, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
    expect_val(S_CMPOP, 32'(bltu)); expect_val(S_BR_EN, 32'd0);
    settle_and_check();
    drive(enc_r(7'h20, 5'd2, 5'd1, 3'd0), 32'h600, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_val(S_ALUOP, 32'(alu_sub)); expect_val(S_ALUMUX2, 32'(alumux2_rs2));
    settle_and_check();
    drive(enc_i(12'h400, 5'd1, 3'd0, 7'h13), 32'h600, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_val(S_ALUOP, 32'(alu_add));
    settle_and_check();

    // lui, load, unknown opcode
    drive({20'h12345, 5'd1, 7'h37}, 32'h700, 32'd0, 32'd1, 1'b0, 1'b0);
    expect_val(S_LOAD_RF, 32'd1); expect_val(S_RFMUX, 32'(rfmux_u_imm));
    settle_and_check();
    drive(enc_i(12'd4, 5'd1, 3'd4, 7'h03), 32'h700, 32'd0, 32'd1, 1'b0, 1'b0);
    expect_val(S_MEM_READ, 32'd1); expect_val(S_RFMUX, 32'(rfmux_lbu));
    settle_and_check();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd0, 32'd1, 1'b0, 1'b0);
    expect_val(S_OPCODE, 32'd0); expect_val(S_LOAD_RF, 32'd0); expect_val(S_TARGET, 32'd0);
    expect_val(S_PCMUX, 32'(pcmux_pc_plus4)); expect_val(S_FLUSH, 32'd0);
    settle_and_check();

    // Randomized conditional branches against the reference model
    for (int k = 0; k < 40; k++) begin
      rf3  = f3_tab[$urandom_range(0, 5)];
      rimm = 13'($urandom) & 13'h1FFE;
      if (rimm == 13'd0) rimm = 13'd2;
      rpc  = $urandom & 32'hFFFF_FFFC;
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rpred = 1'($urandom_range(0, 1));
      rbr  = model_br(rf3, ra, rb);
      rexp_t = rbr ? (rpc + {{19{rimm[12]}}, rimm}) : (rpc + 32'd4);
      drive(enc_b(rimm, 5'd2, 5'd1, rf3), rpc, ra, rb, rpred, 1'b0);
      expect_val(S_BR_EN, {31'd0, rbr}); expect_val(S_TARGET, rexp_t);
      expect_val(S_FLUSH, {31'd0, rbr != rpred});
      settle_and_check();
    end

    // Self-loop halt, sticky across instructions, cleared asynchronously
    drive(enc_b(13'd0, 5'd0, 5'd0, 3'd0), 32'h80, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_val(S_BR_EN, 32'd1); expect_val(S_TARGET, 32'h80); expect_val(S_HALT_EN, HALT_ON);
    expect_val(S_HALTED, 32'd0);
    settle_and_check();
    @(posedge clk);
    expect_val(S_HALTED, HALT_ON);
    settle_and_check();
    drive(32'h0000_0013, 32'h84, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_val(S_HALT_EN, 32'd0); expect_val(S_HALTED, HALT_ON);
    settle_and_check();
    rst = 1'b0;
    expect_val(S_HALTED, 32'd0); expect_val(S_HALT_EN, 32'd0);
    settle_and_check();
    drive(32'h0000_0013, 32'h84, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    expect_val(S_HALTED, 32'd0);
    settle_and_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
